// File: rtl/branch_adder_pkg.sv
// Shared definitions for the branch-target adder.
// Default widths and the program-counter type used by the adder and its users.
package branch_adder_pkg;

   // Default program-counter and immediate widths
   localparam int unsigned PC_W_DEF  = 8;
   localparam int unsigned IMM_W_DEF = 32;

   // Program counter at the default width
   typedef logic [PC_W_DEF-1:0] pc_t;

endpackage : branch_adder_pkg

// File: rtl/branch_adder_core.sv
// Combinational core of the branch-target adder.
// Adds the truncated immediate to the PC and derives the carry and the wrap flag.
module branch_adder_core
   import branch_adder_pkg::*;
#(
   parameter int unsigned PC_W = PC_W_DEF
) (
   input  logic [PC_W-1:0] i_pc,
   input  logic [PC_W-1:0] i_imm,
   input  logic            i_sign,
   output logic [PC_W-1:0] o_sum,
   output logic            o_carry,
   output logic            o_wrap
);

   logic [PC_W:0] w_full;

   // Modular add plus carry; wrap is a carry that disagrees with the offset's sign
   always_comb begin
      w_full  = {1'b0, i_pc} + {1'b0, i_imm};
      o_sum   = w_full[PC_W-1:0];
      o_carry = w_full[PC_W];
      o_wrap  = (o_carry & ~i_sign) | (~o_carry & i_sign);
   end

endmodule : branch_adder_core

// File: rtl/branch_adder.sv
// Registered branch-target adder for the fetch stage.
// Target = (PC + low PC_W bits of the immediate) mod 2^PC_W, one cycle after capture.
// Optional feature: define BRANCH_ADDER_RANGE_CHECK_EN to build the range_err check;
// otherwise range_err is tied low and no range logic exists.
module branch_adder
   import branch_adder_pkg::*;
#(
   parameter int unsigned PC_W  = PC_W_DEF,
   parameter int unsigned IMM_W = IMM_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [PC_W-1:0]  PC,
   input  logic [IMM_W-1:0] signExtImm,
   output logic [PC_W-1:0]  addResult,
   output logic             out_valid,
   output logic             wrap,
   output logic             range_err
);

   logic [PC_W-1:0] w_sum;
   logic            w_unused_carry;
   logic            w_wrap;

   logic [PC_W-1:0] r_sum;
   logic            r_wrap;
   logic            r_valid;

   branch_adder_core #(
      .PC_W (PC_W)
   ) u_core (
      .i_pc    (PC),
      .i_imm   (signExtImm[PC_W-1:0]),
      .i_sign  (signExtImm[IMM_W-1]),
      .o_sum   (w_sum),
      .o_carry (w_unused_carry),
      .o_wrap  (w_wrap)
   );

   // Valid follows in_valid every cycle; cleared immediately by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
      end
   end

   // Result and wrap capture only on valid input, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum  <= '0;
         r_wrap <= 1'b0;
      end else if (in_valid) begin
         r_sum  <= w_sum;
         r_wrap <= w_wrap;
      end
   end

   assign addResult = r_sum;
   assign wrap      = r_wrap;
   assign out_valid = r_valid;

`ifdef BRANCH_ADDER_RANGE_CHECK_EN
   logic [IMM_W-PC_W:0] w_imm_hi;
   logic                w_range_err;
   logic                r_range_err;

   // Upper bits including the PC_W sign position must all match for the offset to fit
   always_comb begin
      w_imm_hi    = signExtImm[IMM_W-1:PC_W-1];
      w_range_err = ~((&w_imm_hi) | ~(|w_imm_hi));
   end

   // Range flag captured alongside the result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_range_err <= 1'b0;
      end else if (in_valid) begin
         r_range_err <= w_range_err;
      end
   end

   assign range_err = r_range_err;
`else
   // Upper immediate bits only matter to the range check
   logic w_unused_imm_hi;
   assign w_unused_imm_hi = ^signExtImm[IMM_W-1:PC_W-1];
   assign range_err       = 1'b0;
`endif

endmodule : branch_adder

// File: tb/tb_branch_adder.sv
// Self-checking bench for branch_adder: directed steps plus a random back-to-back run,
// expected results queued at drive time and compared one cycle later.
module tb_branch_adder;
   import branch_adder_pkg::*;

   localparam int unsigned PW = PC_W_DEF;
   localparam int unsigned IW = IMM_W_DEF;

   typedef struct packed {
      logic [PW-1:0] sum;
      logic          wrap;
      logic          rerr;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   pc_t           pc;
   logic [IW-1:0] imm;
   pc_t           add_result;
   logic          out_valid;
   logic          wrap;
   logic          range_err;

   exp_t sb[$];
   exp_t last;
   int   checks   = 0;
   int   failures = 0;

   branch_adder #(
      .PC_W  (PW),
      .IMM_W (IW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .PC         (pc),
      .signExtImm (imm),
      .addResult  (add_result),
      .out_valid  (out_valid),
      .wrap       (wrap),
      .range_err  (range_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t model(input pc_t p, input logic [IW-1:0] i);
      exp_t          e;
      logic [PW:0]   full;
      logic          c;
      logic          s;
      full   = {1'b0, p} + {1'b0, i[PW-1:0]};
      c      = full[PW];
      s      = i[IW-1];
      e.sum  = full[PW-1:0];
      e.wrap = (c & ~s) | (~c & s);
`ifdef BRANCH_ADDER_RANGE_CHECK_EN
      e.rerr = ($signed(i) < -128) || ($signed(i) > 127);
`else
      e.rerr = 1'b0;
`endif
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_addResult"}, 32'(add_result), 32'h0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
      check({tag, "_wrap"}, 32'(wrap), 32'h0);
      check({tag, "_range_err"}, 32'(range_err), 32'h0);
   endtask

   // Drive one cycle of input, then compare the outputs produced by that edge
   task automatic step(input logic v, input pc_t p, input logic [IW-1:0] i);
      in_valid = v;
      pc       = p;
      imm      = i;
      if (v) sb.push_back(model(p, i));
      @(posedge clk);
      #1;
      check("out_valid", 32'(out_valid), 32'(v));
      if (v) last = sb.pop_front();
      check("addResult", 32'(add_result), 32'(last.sum));
      check("wrap", 32'(wrap), 32'(last.wrap));
      check("range_err", 32'(range_err), 32'(last.rerr));
   endtask

   initial begin
      last     = '0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      pc       = '0;
      imm      = '0;
      #3;
      check_zero("reset_async");

      // Reset held across an edge with valid input present
      in_valid = 1'b1;
      pc       = 8'h10;
      imm      = 32'h0000_0005;
      @(posedge clk);
      #1;
      check_zero("reset_held");

      // Release with no valid input: outputs stay at reset values
      in_valid = 1'b0;
      rst_n    = 1'b1;
      step(1'b0, 8'h33, 32'h0000_0044);

      step(1'b1, 8'h10, 32'h0000_0005);
      step(1'b1, 8'h10, 32'hFFFF_FFFE);
      step(1'b1, 8'h01, 32'hFFFF_FFFE);
      step(1'b1, 8'hFF, 32'h0000_0001);
      step(1'b1, 8'h20, 32'h0000_0100);
      step(1'b0, 8'h55, 32'h1234_5678);
      step(1'b1, 8'h7F, 32'hFFFF_FF80);
      step(1'b1, 8'h80, 32'h0000_007F);
      step(1'b1, 8'h00, 32'hFFFF_FF7F);
      step(1'b0, 8'hAA, 32'h0000_0003);

      for (int n = 0; n < 256; n++) begin
         step(1'b1, pc_t'($urandom_range(255)), $urandom);
         if (n == 128) begin
            // Asynchronous reset between edges clears outputs at once
            #2;
            rst_n = 1'b0;
            #1;
            check_zero("reset_mid");
            sb.delete();
            last = '0;
            @(posedge clk);
            #1;
            check_zero("reset_mid_held");
            #2;
            rst_n = 1'b1;
         end
      end
      step(1'b0, 8'h01, 32'h0000_0001);
      step(1'b0, 8'h02, 32'h0000_0002);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_branch_adder

// File: doc/branch_adder.md
# branch_adder

Registered branch-target adder for the processor's fetch stage. It adds the low `PC_W` bits of the sign-extended branch immediate to the current program counter, modulo 2^`PC_W`, and presents the target one clock later. Status flags report address wrap and out-of-range immediates, for the branch unit and debug logic.

## Interface
Parameters:
- `PC_W`, default 8: program-counter width in bits.
- `IMM_W`, default 32: sign-extended immediate width in bits (must be ≥ `PC_W`).

Ports:
- `clk`, input, 1: rising-edge clock, the single clock domain.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: `PC`/`signExtImm` valid this cycle.
- `PC`, input, `PC_W`: current program counter.
- `signExtImm`, input, `IMM_W`: sign-extended branch offset.
- `addResult`, output, `PC_W`: registered branch target.
- `out_valid`, output, 1: `addResult` and the flags correspond to a captured input.
- `wrap`, output, 1: target crossed the address-space boundary.
- `range_err`, output, 1: immediate not representable in `PC_W` signed bits (only with the range-check macro).

## Operation
- Sum: `addResult = (PC + signExtImm[PC_W-1:0]) mod 2^PC_W`.
  - Bits `IMM_W-1:PC_W` never affect `addResult`.
- Wrap rule, with `c` the carry out of the `PC_W`-bit add and `s = signExtImm[IMM_W-1]`:
  - `wrap = c & ~s` (forward wrap), or
  - `wrap = ~c & s` (backward wrap).
- Range rule: `range_err = 1` when `signExtImm[IMM_W-1:PC_W-1]` are not all equal.
- Capture on rising `clk`:
  - `in_valid = 1`: `addResult`, `wrap` and `range_err` update, and `out_valid = 1`.
  - `in_valid = 0`: `addResult`, `wrap` and `range_err` hold their last values, and `out_valid = 0`.
- No backpressure: a new input is accepted every cycle.
- Reset (`rst_n = 0`), asynchronous:
  - `addResult = 0`, `out_valid = 0`, `wrap = 0`, `range_err = 0`.
  - These values hold until the first rising edge with `rst_n = 1`.
  - Reset asserted mid-stream discards the in-flight result immediately.

## Timing
- Latency: 1 cycle. An input sampled at edge N is visible on the outputs after edge N.
- Throughput: 1 result per cycle.
- `addResult`, `wrap` and `range_err` always change together with `out_valid`, from the same edge.
- All outputs are driven directly from flops; there is no combinational path from input to output.
- The combinational add plus the flag logic must close within one `clk` period.

## Configuration
- Macro `BRANCH_ADDER_RANGE_CHECK_EN`.
- Defined: the `range_err` logic and flop are built as described in Operation.
- Undefined:
  - The `range_err` port still exists and is tied to 0.
  - No range-check logic is synthesised.
  - `addResult` and `wrap` behaviour is unchanged.

## Structure
- Shared package `branch_adder_pkg` holds:
  - the default widths `PC_W_DEF = 8` and `IMM_W_DEF = 32`;
  - the typedef `pc_t` (logic [`PC_W_DEF`-1:0]).
- One combinational sub-module, `branch_adder_core`:
  - inputs: PC and the truncated immediate;
  - outputs: sum, carry and the wrap flag.
- The top level contains the valid and result registers, the reset logic and the optional range check.

## Test plan
1. Reset, then with `rst_n = 0`: all outputs are 0. Release reset with `in_valid = 0`: outputs stay 0.
2. `PC = 0x10`, `signExtImm = 0x00000005` -> next cycle `addResult = 0x15`, `wrap = 0`, `out_valid = 1`.
3. `PC = 0x10`, `signExtImm = 0xFFFFFFFE` -> `addResult = 0x0E`, `wrap = 0`. Then `PC = 0x01`, `signExtImm = 0xFFFFFFFE` -> `addResult = 0xFF`, `wrap = 1`.
4. `PC = 0xFF`, `signExtImm = 0x00000001` -> `addResult = 0x00`, `wrap = 1`.
5. With the macro defined, `PC = 0x20`, `signExtImm = 0x00000100` -> `addResult = 0x20`, `range_err = 1`. Without the macro, the same stimulus gives `range_err = 0`.
6. 256 random `PC`/`signExtImm` pairs, back-to-back -> each `addResult` equals `(PC + imm[7:0]) mod 256` one cycle later. Assert `rst_n` mid-stream -> outputs go to 0 without waiting for a clock edge.
